// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: redirect priority encoding and PC defaults.
package mips_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [PC_W-1:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam int unsigned     PC_STEP_DEF      = 4;

  // Ordered so that a numerically larger value is a higher-priority redirect
  typedef enum logic [2:0] {
    PRIO_NONE   = 3'd0,
    PRIO_BRANCH = 3'd1,
    PRIO_JUMP   = 3'd2,
    PRIO_JR     = 3'd3,
    PRIO_ERET   = 3'd4,
    PRIO_EXC    = 3'd5
  } redirect_prio_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC bus between hazard/branch logic (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned N_BITS = 32
);

  logic              stall_i;
  logic              branch_taken_i;
  logic [N_BITS-1:0] branch_target_i;
  logic              jump_i;
  logic [N_BITS-1:0] jump_target_i;
  logic              jr_i;
  logic [N_BITS-1:0] jr_target_i;
  logic              eret_i;
  logic              exception_i;
  logic [N_BITS-1:0] exc_pc_i;
  logic [N_BITS-1:0] pc_o;
  logic [N_BITS-1:0] pc_plus4_o;
  logic [N_BITS-1:0] epc_o;
  logic              redirect_pending_o;
  logic              addr_err_o;

  modport master (
    output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           jr_i, jr_target_i, eret_i, exception_i, exc_pc_i,
    input  pc_o, pc_plus4_o, epc_o, redirect_pending_o, addr_err_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           jr_i, jr_target_i, eret_i, exception_i, exc_pc_i,
    output pc_o, pc_plus4_o, epc_o, redirect_pending_o, addr_err_o
  );

endinterface

// File: rtl/pc_redirect_select.sv
// Combinational priority encoder picking the highest-priority redirect request this cycle.
module pc_redirect_select
  import mips_pkg::*;
#(
  parameter int unsigned       N_BITS     = PC_W,
  parameter logic [N_BITS-1:0] EXC_VECTOR = N_BITS'(EXC_VECTOR_DEF)
) (
  input  logic              exception,
  input  logic              eret,
  input  logic [N_BITS-1:0] epc,
  input  logic              jr,
  input  logic [N_BITS-1:0] jr_target,
  input  logic              jump,
  input  logic [N_BITS-1:0] jump_target,
  input  logic              branch,
  input  logic [N_BITS-1:0] branch_target,
  output redirect_prio_e    prio_c,
  output logic [N_BITS-1:0] target_c,
  output logic              misaligned_c
);

  always_comb begin
    prio_c   = PRIO_NONE;
    target_c = '0;
    if (exception) begin
      prio_c   = PRIO_EXC;
      target_c = EXC_VECTOR;
    end else if (eret) begin
      prio_c   = PRIO_ERET;
      target_c = epc;
    end else if (jr) begin
      prio_c   = PRIO_JR;
      target_c = jr_target;
    end else if (jump) begin
      prio_c   = PRIO_JUMP;
      target_c = jump_target;
    end else if (branch) begin
      prio_c   = PRIO_BRANCH;
      target_c = branch_target;
    end
  end

  // The exception vector is trusted and never flagged
  assign misaligned_c = (prio_c != PRIO_NONE) && (prio_c != PRIO_EXC) &&
                        (target_c[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with redirect buffering across stalls, EPC and misalignment trap.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned       N_BITS       = PC_W,
  parameter logic [N_BITS-1:0] RESET_VECTOR = N_BITS'(RESET_VECTOR_DEF),
  parameter logic [N_BITS-1:0] EXC_VECTOR   = N_BITS'(EXC_VECTOR_DEF),
  parameter int unsigned       PC_STEP      = PC_STEP_DEF
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [N_BITS-1:0] pc_q, pc_d;
  logic [N_BITS-1:0] epc_q, epc_d;
  logic              buf_valid_q, buf_valid_d;
  redirect_prio_e    buf_prio_q, buf_prio_d;
  logic [N_BITS-1:0] buf_target_q, buf_target_d;
  logic              addr_err_q, addr_err_d;

  redirect_prio_e    req_prio;
  logic [N_BITS-1:0] req_target;
  logic              req_misaligned;

  logic              req_present;
  logic              req_beats_buf;
  logic              sel_redirect;
  logic              sel_misaligned;
  logic [N_BITS-1:0] sel_target;

  pc_redirect_select #(
    .N_BITS     (N_BITS),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_select (
    .exception     (bus.exception_i),
    .eret          (bus.eret_i),
    .epc           (epc_q),
    .jr            (bus.jr_i),
    .jr_target     (bus.jr_target_i),
    .jump          (bus.jump_i),
    .jump_target   (bus.jump_target_i),
    .branch        (bus.branch_taken_i),
    .branch_target (bus.branch_target_i),
    .prio_c        (req_prio),
    .target_c      (req_target),
    .misaligned_c  (req_misaligned)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      buf_valid_q  <= 1'b0;
      buf_prio_q   <= PRIO_NONE;
      buf_target_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      buf_valid_q  <= buf_valid_d;
      buf_prio_q   <= buf_prio_d;
      buf_target_q <= buf_target_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Next-state: exception first, then stall buffering, then release/free-run selection
  always_comb begin
    pc_d           = pc_q;
    epc_d          = epc_q;
    buf_valid_d    = buf_valid_q;
    buf_prio_d     = buf_prio_q;
    buf_target_d   = buf_target_q;
    addr_err_d     = 1'b0;
    req_present    = (req_prio != PRIO_NONE);
    req_beats_buf  = req_present && (!buf_valid_q || (req_prio >= buf_prio_q));
    sel_redirect   = 1'b0;
    sel_misaligned = 1'b0;
    sel_target     = pc_q + N_BITS'(PC_STEP);

    if (bus.exception_i) begin
      pc_d        = EXC_VECTOR;
      epc_d       = bus.exc_pc_i;
      buf_valid_d = 1'b0;
      buf_prio_d  = PRIO_NONE;
    end else if (bus.stall_i) begin
      if (req_beats_buf) begin
        buf_valid_d  = 1'b1;
        buf_prio_d   = req_prio;
        buf_target_d = req_target;
      end
    end else begin
      buf_valid_d = 1'b0;
      buf_prio_d  = PRIO_NONE;
      if (req_beats_buf) begin
        sel_redirect   = 1'b1;
        sel_misaligned = req_misaligned;
        sel_target     = req_target;
      end else if (buf_valid_q) begin
        sel_redirect   = 1'b1;
        sel_misaligned = (buf_target_q[1:0] != 2'b00);
        sel_target     = buf_target_q;
      end

      if (sel_redirect && sel_misaligned) begin
        pc_d       = EXC_VECTOR;
        epc_d      = pc_q;
        addr_err_d = 1'b1;
      end else begin
        pc_d = sel_target;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.pc_o               = pc_q;
    bus.pc_plus4_o         = pc_q + N_BITS'(PC_STEP);
    bus.epc_o              = epc_q;
    bus.redirect_pending_o = buf_valid_q;
    bus.addr_err_o         = addr_err_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table fed through an expected-value scoreboard.
module tb_pc_sequencer;

  logic clk;
  logic reset;

  pc_sequencer_if #(.N_BITS(32)) bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_t;
    logic        j;
    logic [31:0] j_t;
    logic        jr;
    logic [31:0] jr_t;
    logic        eret;
    logic        exc;
    logic [31:0] exc_pc;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic        e_pend;
    logic        e_aerr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pend;
    logic        aerr;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic stall, logic br, logic [31:0] br_t, logic j, logic [31:0] j_t,
                              logic jr, logic [31:0] jr_t, logic eret, logic exc, logic [31:0] exc_pc,
                              logic [31:0] e_pc, logic [31:0] e_epc, logic e_pend, logic e_aerr);
    vec_t v;
    v.stall = stall; v.br = br; v.br_t = br_t; v.j = j; v.j_t = j_t;
    v.jr = jr; v.jr_t = jr_t; v.eret = eret; v.exc = exc; v.exc_pc = exc_pc;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_pend = e_pend; v.e_aerr = e_aerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.stall_i         = v.stall;
    bus.branch_taken_i  = v.br;
    bus.branch_target_i = v.br_t;
    bus.jump_i          = v.j;
    bus.jump_target_i   = v.j_t;
    bus.jr_i            = v.jr;
    bus.jr_target_i     = v.jr_t;
    bus.eret_i          = v.eret;
    bus.exception_i     = v.exc;
    bus.exc_pc_i        = v.exc_pc;
  endtask

  // Called at a negedge: drive, push expectation, compare one cycle later, return at next negedge
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    drive(v);
    e.pc = v.e_pc; e.epc = v.e_epc; e.pend = v.e_pend; e.aerr = v.e_aerr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("pc[%0d]", idx), bus.pc_o, e.pc);
      check($sformatf("pc_plus4[%0d]", idx), bus.pc_plus4_o, e.pc + 32'd4);
      check($sformatf("epc[%0d]", idx), bus.epc_o, e.epc);
      check($sformatf("pending[%0d]", idx), 32'(bus.redirect_pending_o), 32'(e.pend));
      check($sformatf("addr_err[%0d]", idx), 32'(bus.addr_err_o), 32'(e.aerr));
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h8000_0180;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          stall br br_t          j  j_t           jr jr_t          er ex exc_pc        e_pc          e_epc         pd ae
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            32'h0040_0004, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            32'h0040_0008, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            32'h0040_000C, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            32'h0040_0010, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 32'h0040_0100, 0, 0,            0, 0,            0, 0, 0,            32'h0040_0010, 32'h0,        1, 0));
    vecs.push_back(mk(1, 0, 0,            1, 32'h0040_0200, 0, 0,            0, 0, 0,            32'h0040_0010, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            32'h0040_0200, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 32'h0040_0300, 0, 0,            0, 0,            0, 0, 0,            32'h0040_0200, 32'h0,        1, 0));
    vecs.push_back(mk(1, 0, 0,            0, 0,            0, 0,            0, 1, 32'h0040_0020, EV,            32'h0040_0020, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            1, 0, 0,            32'h0040_0020, 32'h0040_0020, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h0040_0040, 0, 0,            0, 0, 0,            32'h0040_0040, 32'h0040_0020, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0040_0102, 0, 0, 0,            EV,            32'h0040_0040, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            32'h8000_0184, 32'h0040_0040, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0040_0600, 0, 0,            1, 32'h0040_0500, 0, 0, 0,            32'h0040_0500, 32'h0040_0040, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0040_0003, 0, 1, 32'h0040_0504, EV,            32'h0040_0504, 0, 0));
    vecs.push_back(mk(1, 0, 0,            1, 32'h0040_0800, 0, 0,            0, 0, 0,            EV,            32'h0040_0504, 1, 0));
    vecs.push_back(mk(1, 0, 0,            1, 32'h0040_0880, 0, 0,            0, 0, 0,            EV,            32'h0040_0504, 1, 0));
    vecs.push_back(mk(1, 1, 32'h0040_0900, 0, 0,            0, 0,            0, 0, 0,            EV,            32'h0040_0504, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0040_0A00, 0, 0,            0, 0,            0, 0, 0,            32'h0040_0880, 32'h0040_0504, 0, 0));
    vecs.push_back(mk(1, 0, 0,            1, 32'h0040_0C00, 0, 0,            0, 0, 0,            32'h0040_0880, 32'h0040_0504, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0040_0D00, 0, 0, 0,            32'h0040_0D00, 32'h0040_0504, 0, 0));
    vecs.push_back(mk(1, 1, 32'h0040_0E01, 0, 0,            0, 0,            0, 0, 0,            32'h0040_0D00, 32'h0040_0504, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            EV,            32'h0040_0D00, 0, 1));
    vecs.push_back(mk(1, 0, 0,            0, 0,            0, 0,            0, 0, 0,            EV,            32'h0040_0D00, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            1, 0, 0,            32'h0040_0D00, 32'h0040_0D00, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,            0, 0, 0,            32'hFFFF_FFFC, 32'h0040_0D00, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            32'h0000_0000, 32'h0040_0D00, 0, 0));
    vecs.push_back(mk(1, 0, 0,            1, 32'h0040_1000, 0, 0,            0, 0, 0,            32'h0000_0000, 32'h0040_0D00, 1, 0));

    reset = 1'b0;
    drive(idle);
    repeat (3) @(negedge clk);
    check("reset_pc", bus.pc_o, RV);
    check("reset_pending", 32'(bus.redirect_pending_o), 32'd0);
    reset = 1'b1;
    #1;
    check("post_reset_pc", bus.pc_o, RV);
    check("post_reset_plus4", bus.pc_plus4_o, 32'h0040_0004);
    check("post_reset_epc", bus.epc_o, 32'h0);
    check("post_reset_addr_err", 32'(bus.addr_err_o), 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset between edges while the buffer holds a jump
    bus.stall_i = 1'b1;
    bus.jump_i  = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_reset_pc", bus.pc_o, RV);
    check("async_reset_pending", 32'(bus.redirect_pending_o), 32'd0);
    check("async_reset_epc", bus.epc_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 32'h0, 0, 0), 100);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 32'h0, 0, 0), 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-generation fetch-stage program counter for the MIPS core.
- Replaces the plain hold/load PC register with these features:
  - an internal next-PC priority selector;
  - a pending-redirect buffer that keeps branch, jump and eret redirects raised during a stall;
  - an exception vector and an EPC register;
  - misaligned-target detection.
- Sits between the hazard/branch logic and instruction memory.
- Drives the fetch address and PC+4 to IF/ID.

Parameters:
- N_BITS, 32: PC, target and EPC width.
- RESET_VECTOR, 32'h0040_0000: PC value on reset.
- EXC_VECTOR, 32'h8000_0180: PC loaded on any exception.
- PC_STEP, 4: sequential increment.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- stall_i  in  1  1 = hold PC (hazard unit).
- branch_taken_i  in  1  conditional branch resolved taken.
- branch_target_i  in  N_BITS  branch target.
- jump_i  in  1  j/jal.
- jump_target_i  in  N_BITS  jump target.
- jr_i  in  1  jr/jalr.
- jr_target_i  in  N_BITS  register target.
- eret_i  in  1  return from exception.
- exception_i  in  1  exception raised by a later stage.
- exc_pc_i  in  N_BITS  address of the faulting instruction.
- pc_o  out  N_BITS  current fetch address.
- pc_plus4_o  out  N_BITS  pc_o + PC_STEP, combinational.
- epc_o  out  N_BITS  exception program counter.
- redirect_pending_o  out  1  a buffered redirect is waiting for stall release.
- addr_err_o  out  1  one-cycle pulse: misaligned redirect trapped.

Behaviour:
- Reset values (asynchronous, immediate): pc_o = RESET_VECTOR, epc_o = 0, pending buffer empty, redirect_pending_o = 0, addr_err_o = 0.
- Request priority, highest first: exception_i > eret_i > jr_i > jump_i > branch_taken_i > sequential.
- exception_i:
  - Ignores stall_i.
  - Next edge: pc_o <= EXC_VECTOR, epc_o <= exc_pc_i.
  - Pending buffer cleared.
- eret_i: target = epc_o as it is before the edge.
- No stall, no pending entry: pc_o <= highest-priority target, or pc_o + PC_STEP if no request.
- Stall with a redirect (eret, jr, jump or branch) present:
  - pc_o holds.
  - Buffer captures target and priority.
  - A later stalled-cycle redirect replaces the buffer only if its priority is >= the buffered priority.
  - redirect_pending_o = 1 while the buffer is valid.
- Stall release (stall_i = 0) with the buffer valid:
  - The buffered target is used.
  - A same-cycle redirect of priority >= buffered priority wins instead.
  - Buffer cleared on that edge.
- Stall with no redirect: pc_o and the buffer both hold.
- Misalignment check:
  - Applies to the selected non-sequential target, including a buffered one.
  - Misaligned means target[1:0] != 0 (exception vector excluded).
  - On that edge: pc_o <= EXC_VECTOR, epc_o <= pc_o as it is before the edge, addr_err_o = 1 for exactly one cycle, buffer cleared.
  - A simultaneous exception_i takes precedence: no addr_err_o, and epc_o <= exc_pc_i.
- Arithmetic:
  - Addition is modulo 2^N_BITS.
  - pc_o = 2^N_BITS - 4 steps to 0 with no flag.
- Latency: one cycle from request to pc_o for every source.
- Reset mid-stall or with the buffer valid: all state returns to the reset values; the buffered redirect is discarded.

Decomposition:
- Shared package, mips_pkg:
  - redirect-priority encoding: NONE, BRANCH, JUMP, JR, ERET, EXC;
  - RESET_VECTOR and EXC_VECTOR defaults;
  - PC_STEP.
- One natural sub-module, pc_redirect_select:
  - combinational priority encoder;
  - outputs target, priority and a misalign flag.
- Register, buffer and EPC logic live in pc_sequencer.

Test Plan:
- Reset, then 3 free-running cycles -> pc_o = 0x00400000, 0x00400004, 0x00400008, 0x0040000C. pc_plus4_o tracks pc_o + 4.
- Sequence at pc_o = 0x00400010:
  - stall_i = 1 with branch_taken_i = 1, branch_target_i = 0x00400100 -> pc_o holds, redirect_pending_o = 1.
  - Next stalled cycle, jump_i = 1, jump_target_i = 0x00400200 -> buffer replaced.
  - Release -> pc_o = 0x00400200, redirect_pending_o = 0.
- exception_i with exc_pc_i = 0x00400020 while stall_i = 1 and the buffer is valid -> pc_o = 0x80000180, epc_o = 0x00400020, buffer cleared. eret_i one cycle later -> pc_o = 0x00400020.
- jr_i = 1, jr_target_i = 0x00400102 at pc_o = 0x00400040 -> pc_o = 0x80000180, epc_o = 0x00400040, addr_err_o high for one cycle.
- jr_i = 1 and branch_taken_i = 1 in the same cycle -> pc_o = jr_target_i. exception_i with jr_i misaligned -> addr_err_o stays 0.
- reset driven low mid-stall with the buffer valid, between clock edges -> pc_o = 0x00400000 immediately. After release, the buffered target is never applied.
